// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO peripheral controller.
// Region codes are the 12-bit values of addr[31:20]; any other code is an
// invalid region. Error-bit positions and timebase ratios live here too.
package mmio_pkg;

   typedef enum logic [11:0] {
      RGN_DATA      = 12'h000,
      RGN_VGA_LINE  = 12'h001,
      RGN_CURSOR    = 12'h002,
      RGN_KBD_ASCII = 12'h003,
      RGN_SW        = 12'h004,
      RGN_LED       = 12'h005,
      RGN_HEX       = 12'h006,
      RGN_CLK_S     = 12'h007,
      RGN_CLK_MS    = 12'h008,
      RGN_CLK_US    = 12'h009,
      RGN_ERROR     = 12'h00A
   } region_e;

   localparam int ERR_RD_INVALID = 0;
   localparam int ERR_WR_INVALID = 1;
   localparam int ERR_KBD_OVF    = 2;

   localparam int HZ_PER_MHZ = 1_000_000;
   localparam int US_PER_MS  = 1000;
   localparam int MS_PER_S   = 1000;

   typedef struct packed {
      logic    valid;
      region_e region;
   } decode_t;

   // Maps addr[31:20] to a region; valid is low for unmapped codes.
   function automatic decode_t decode_region(input logic [11:0] code);
      decode_t d;
      d.valid  = 1'b1;
      d.region = RGN_DATA;
      case (code)
         RGN_DATA:      d.region = RGN_DATA;
         RGN_VGA_LINE:  d.region = RGN_VGA_LINE;
         RGN_CURSOR:    d.region = RGN_CURSOR;
         RGN_KBD_ASCII: d.region = RGN_KBD_ASCII;
         RGN_SW:        d.region = RGN_SW;
         RGN_LED:       d.region = RGN_LED;
         RGN_HEX:       d.region = RGN_HEX;
         RGN_CLK_S:     d.region = RGN_CLK_S;
         RGN_CLK_MS:    d.region = RGN_CLK_MS;
         RGN_CLK_US:    d.region = RGN_CLK_US;
         RGN_ERROR:     d.region = RGN_ERROR;
         default:       d.valid  = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous FIFO buffering keyboard ASCII codes.
// Ports: clock, reset (sync, active-high), push/din (write), pop (read),
//        dout (head entry, combinational), count (occupancy), full, empty.
// The caller never pushes when full without a same-cycle pop, and never pops
// when empty.
module kbd_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // NOTE: storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= din;
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/mmio_periph_ctrl.sv
// Memory-mapped peripheral controller between a CPU data port and board I/O.
// Ports: clock/reset (sync, active-high); CPU side addr, wdata, we, re, rdata
//        (registered, 1-cycle latency); data memory mem_we/mem_rdata; board
//        side sw, kbd_valid/kbd_ascii, led, hex, line_offset, cur_h, cur_v,
//        cursor_blink.
// Holds display registers, us/ms/s timers driven by enable-tick prescalers,
// a keyboard FIFO and a sticky error register.
module mmio_periph_ctrl
   import mmio_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int KBD_DEPTH = 16,
   parameter int NUM_LED   = 16,
   parameter int NUM_SW    = 16,
   parameter int BLINK_MS  = 500
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   input  logic               we,
   input  logic               re,
   output logic [31:0]        rdata,
   output logic               mem_we,
   input  logic [31:0]        mem_rdata,
   input  logic [NUM_SW-1:0]  sw,
   input  logic               kbd_valid,
   input  logic [7:0]         kbd_ascii,
   output logic [NUM_LED-1:0] led,
   output logic [31:0]        hex,
   output logic [4:0]         line_offset,
   output logic [6:0]         cur_h,
   output logic [4:0]         cur_v,
   output logic               cursor_blink
);

   localparam int US_DIV  = CLK_HZ / HZ_PER_MHZ;
   localparam int US_W    = $clog2(US_DIV + 1);
   localparam int MS_W    = $clog2(US_PER_MS);
   localparam int S_W     = $clog2(MS_PER_S);
   localparam int BLINK_W = $clog2(BLINK_MS + 1);
   localparam int CNT_W   = $clog2(KBD_DEPTH) + 1;

   decode_t dec;
   assign dec = decode_region(addr[31:20]);

   logic unused_addr;
   assign unused_addr = ^addr[19:0];

   // A simultaneous write takes the port; the read is dropped.
   logic rd_en;
   assign rd_en = re && !we;

   function automatic logic hit(input decode_t d, input region_e r);
      return d.valid && (d.region == r);
   endfunction

   assign mem_we = we && hit(dec, RGN_DATA);

   // ---------------- keyboard FIFO ----------------
   logic             kbd_push_req, kbd_push, kbd_pop, kbd_full, kbd_empty;
   logic [7:0]       kbd_head;
   logic [CNT_W-1:0] kbd_count;

   assign kbd_push_req = kbd_valid && (kbd_ascii != 8'h00);
   assign kbd_pop      = rd_en && hit(dec, RGN_KBD_ASCII) && !kbd_empty;
   // A same-cycle pop frees the slot, so full+push+pop is not an overflow.
   assign kbd_push     = kbd_push_req && (!kbd_full || kbd_pop);

   kbd_fifo #(.DEPTH(KBD_DEPTH), .WIDTH(8)) u_kbd_fifo (
      .clock (clock),
      .reset (reset),
      .push  (kbd_push),
      .din   (kbd_ascii),
      .pop   (kbd_pop),
      .dout  (kbd_head),
      .count (kbd_count),
      .full  (kbd_full),
      .empty (kbd_empty)
   );

   // ---------------- prescalers ----------------
   logic [US_W-1:0]    us_cnt;
   logic [MS_W-1:0]    ms_cnt;
   logic [S_W-1:0]     s_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic               us_tick, ms_tick, s_tick, blink_tick;

   assign us_tick    = (us_cnt == US_W'(US_DIV - 1));
   assign ms_tick    = us_tick && (ms_cnt == MS_W'(US_PER_MS - 1));
   assign s_tick     = ms_tick && (s_cnt == S_W'(MS_PER_S - 1));
   assign blink_tick = ms_tick && (blink_cnt == BLINK_W'(BLINK_MS - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         us_cnt       <= '0;
         ms_cnt       <= '0;
         s_cnt        <= '0;
         blink_cnt    <= '0;
         cursor_blink <= 1'b0;
      end else begin
         us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
         if (us_tick) ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
         if (ms_tick) s_cnt <= s_tick ? '0 : s_cnt + 1'b1;
         if (ms_tick) blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
         if (blink_tick) cursor_blink <= !cursor_blink;
      end
   end

   // ---------------- register file ----------------
   logic [31:0] clk_us, clk_ms, clk_s;
   logic [2:0]  error, err_set, err_clr;

   assign err_set[ERR_RD_INVALID] = rd_en && !dec.valid;
   assign err_set[ERR_WR_INVALID] = we && (!dec.valid || dec.region == RGN_SW
                                           || dec.region == RGN_KBD_ASCII);
   assign err_set[ERR_KBD_OVF]    = kbd_push_req && kbd_full && !kbd_pop;
   assign err_clr = (we && hit(dec, RGN_ERROR)) ? wdata[2:0] : 3'b000;

   always_ff @(posedge clock) begin
      if (reset) begin
         led         <= '0;
         hex         <= '0;
         line_offset <= '0;
         cur_h       <= '0;
         cur_v       <= '0;
         clk_us      <= '0;
         clk_ms      <= '0;
         clk_s       <= '0;
         error       <= '0;
      end else begin
         if (we && hit(dec, RGN_VGA_LINE)) line_offset <= wdata[4:0];
         if (we && hit(dec, RGN_CURSOR))   {cur_v, cur_h} <= wdata[11:0];
         if (we && hit(dec, RGN_LED))      led <= wdata[NUM_LED-1:0];
         if (we && hit(dec, RGN_HEX))      hex <= wdata;
         // A preset write overrides a coincident tick.
         if (we && hit(dec, RGN_CLK_US))   clk_us <= wdata;
         else if (us_tick)                 clk_us <= clk_us + 1'b1;
         if (we && hit(dec, RGN_CLK_MS))   clk_ms <= wdata;
         else if (ms_tick)                 clk_ms <= clk_ms + 1'b1;
         if (we && hit(dec, RGN_CLK_S))    clk_s <= wdata;
         else if (s_tick)                  clk_s <= clk_s + 1'b1;
         // Set beats write-1-to-clear in the same cycle.
         error <= (error & ~err_clr) | err_set;
      end
   end

   // ---------------- read path ----------------
   logic [31:0] rd_val;
   logic [31:0] rdata_q;
   logic        data_sel;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      rd_val = '0;
      if (dec.valid) begin
         case (dec.region)
            RGN_VGA_LINE:  rd_val = {27'b0, line_offset};
            RGN_CURSOR:    rd_val = {20'b0, cur_v, cur_h};
            RGN_KBD_ASCII: rd_val = kbd_empty ? 32'h0
                                              : {16'h0, 8'(kbd_count), kbd_head};
            RGN_SW:        rd_val = 32'(sw);
            RGN_LED:       rd_val = 32'(led);
            RGN_HEX:       rd_val = hex;
            RGN_CLK_S:     rd_val = clk_s;
            RGN_CLK_MS:    rd_val = clk_ms;
            RGN_CLK_US:    rd_val = clk_us;
            RGN_ERROR:     rd_val = {29'b0, error};
            default:       rd_val = '0;
         endcase
      end
   end

   // data_sel steers the memory's own registered output onto rdata until the
   // next accepted read selects a peripheral instead.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q  <= '0;
         data_sel <= 1'b0;
      end else if (rd_en) begin
         rdata_q  <= rd_val;
         data_sel <= hit(dec, RGN_DATA);
      end
   end

   assign rdata = data_sel ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mmio_periph_ctrl.sv
`timescale 1ns/1ps
module tb_mmio_periph_ctrl;
   import mmio_pkg::*;

   localparam int CLK_HZ    = 1_000_000;
   localparam int KBD_DEPTH = 16;
   localparam int NUM_LED   = 16;
   localparam int NUM_SW    = 16;
   localparam int BLINK_MS  = 5;

   logic               clock, reset;
   logic [31:0]        addr, wdata, rdata, mem_rdata, hex;
   logic               we, re, mem_we, kbd_valid, cursor_blink;
   logic [NUM_SW-1:0]  sw;
   logic [7:0]         kbd_ascii;
   logic [NUM_LED-1:0] led;
   logic [4:0]         line_offset, cur_v;
   logic [6:0]         cur_h;

   mmio_periph_ctrl #(
      .CLK_HZ(CLK_HZ), .KBD_DEPTH(KBD_DEPTH), .NUM_LED(NUM_LED),
      .NUM_SW(NUM_SW), .BLINK_MS(BLINK_MS)
   ) dut (
      .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
      .re(re), .rdata(rdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .sw(sw), .kbd_valid(kbd_valid), .kbd_ascii(kbd_ascii), .led(led),
      .hex(hex), .line_offset(line_offset), .cur_h(cur_h), .cur_v(cur_v),
      .cursor_blink(cursor_blink)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Timekeeping is derived from k, the number of edges since reset released:
   // with one us per cycle, a ms tick lands on every k divisible by 1000.
   longint      k = 0;
   logic [15:0] m_led = '0;
   logic [31:0] m_hex = '0, m_us = '0, m_ms = '0, m_s = '0, m_rdata = '0;
   logic [4:0]  m_line = '0;
   logic [11:0] m_cur = '0;
   logic [2:0]  m_err = '0;
   bit          m_sel = 0;
   logic [7:0]  q[$];

   function automatic bit is_valid(input logic [11:0] c);
      case (c)
         RGN_DATA, RGN_VGA_LINE, RGN_CURSOR, RGN_KBD_ASCII, RGN_SW, RGN_LED,
         RGN_HEX, RGN_CLK_S, RGN_CLK_MS, RGN_CLK_US, RGN_ERROR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clock) begin
      logic [11:0] c;
      bit          v;
      logic [2:0]  set, clr;
      if (reset) begin
         k = 0; m_led = '0; m_hex = '0; m_us = '0; m_ms = '0; m_s = '0;
         m_rdata = '0; m_line = '0; m_cur = '0; m_err = '0; m_sel = 0;
         q.delete();
      end else begin
         k++;
         c = addr[31:20];
         v = is_valid(c);
         set = '0;
         clr = '0;
         if (re && !we) begin
            if (!v) begin
               m_sel = 0; m_rdata = '0; set[0] = 1'b1;
            end else if (c == RGN_DATA) begin
               m_sel = 1;
            end else begin
               m_sel = 0;
               case (c)
                  RGN_VGA_LINE: m_rdata = {27'b0, m_line};
                  RGN_CURSOR:   m_rdata = {20'b0, m_cur};
                  RGN_SW:       m_rdata = {16'b0, sw};
                  RGN_LED:      m_rdata = {16'b0, m_led};
                  RGN_HEX:      m_rdata = m_hex;
                  RGN_CLK_S:    m_rdata = m_s;
                  RGN_CLK_MS:   m_rdata = m_ms;
                  RGN_CLK_US:   m_rdata = m_us;
                  RGN_ERROR:    m_rdata = {29'b0, m_err};
                  default: begin
                     if (q.size() != 0) begin
                        m_rdata = {16'h0, 8'(q.size()), q[0]};
                        void'(q.pop_front());
                     end else m_rdata = '0;
                  end
               endcase
            end
         end
         if (we) begin
            if (!v || c == RGN_SW || c == RGN_KBD_ASCII) set[1] = 1'b1;
            else case (c)
               RGN_VGA_LINE: m_line = wdata[4:0];
               RGN_CURSOR:   m_cur = wdata[11:0];
               RGN_LED:      m_led = wdata[15:0];
               RGN_HEX:      m_hex = wdata;
               RGN_ERROR:    clr = wdata[2:0];
               default: ;
            endcase
         end
         if (kbd_valid && kbd_ascii != 8'h00) begin
            if (q.size() < KBD_DEPTH) q.push_back(kbd_ascii);
            else set[2] = 1'b1;
         end
         m_us = (we && c == RGN_CLK_US) ? wdata : m_us + 1;
         m_ms = (we && c == RGN_CLK_MS) ? wdata : ((k % 1000 == 0) ? m_ms + 1 : m_ms);
         m_s  = (we && c == RGN_CLK_S)  ? wdata : ((k % 1_000_000 == 0) ? m_s + 1 : m_s);
         m_err = (m_err & ~clr) | set;
      end
   end

   // One compare process: all outputs against the model, every cycle.
   always @(posedge clock) begin
      #1;
      check("rdata", rdata, m_sel ? mem_rdata : m_rdata);
      check("led", 32'(led), 32'(m_led));
      check("hex", hex, m_hex);
      check("line_offset", 32'(line_offset), 32'(m_line));
      check("cur_h", 32'(cur_h), 32'(m_cur[6:0]));
      check("cur_v", 32'(cur_v), 32'(m_cur[11:7]));
      check("cursor_blink", 32'(cursor_blink), 32'((k / (1000 * BLINK_MS)) % 2));
      check("mem_we", 32'(mem_we), 32'(we && addr[31:20] == RGN_DATA));
   end

   // ---------------- stimulus (driven on negedge) ----------------
   task automatic wr(input logic [11:0] r, input logic [31:0] d);
      addr = {r, 20'h0}; wdata = d; we = 1'b1;
      @(negedge clock);
      we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      addr = a; re = 1'b1;
      @(negedge clock);
      re = 1'b0;
   endtask

   task automatic key(input logic [7:0] ch);
      kbd_ascii = ch; kbd_valid = 1'b1;
      @(negedge clock);
      kbd_valid = 1'b0;
   endtask

   localparam logic [31:0] A_KBD = {RGN_KBD_ASCII, 20'h0};
   localparam logic [31:0] A_ERR = {RGN_ERROR, 20'h0};

   initial begin
      reset = 1'b1; addr = '0; wdata = '0; we = 0; re = 0;
      mem_rdata = 32'h0; sw = 16'h3C5A; kbd_valid = 0; kbd_ascii = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("rst_led", 32'(led), 32'h0);
      check("rst_hex", hex, 32'h0);
      check("rst_blink", 32'(cursor_blink), 32'h0);
      rd(A_KBD);              check("rst_kbd", rdata, 32'h0);
      rd(A_ERR);              check("rst_err", rdata, 32'h0);

      wr(RGN_LED, 32'h0000_A5A5);
      rd({RGN_LED, 20'h0});   check("led_rd", rdata, 32'h0000_A5A5);
      // 0xC8A: cur_h = bits[6:0] = 0x0A, cur_v = bits[11:7] = 5'b11001
      wr(RGN_CURSOR, 32'h0000_0C8A);
      check("cur_h", 32'(cur_h), 32'h0A);
      check("cur_v", 32'(cur_v), 32'd25);
      rd({RGN_SW, 20'h0});    check("sw_rd", rdata, 32'h0000_3C5A);

      key(8'h41); key(8'h42);
      rd(A_KBD);              check("kbd_1", rdata, 32'h0000_0241);
      rd(A_KBD);              check("kbd_2", rdata, 32'h0000_0142);
      rd(A_KBD);              check("kbd_3", rdata, 32'h0);

      for (int i = 0; i < 17; i++) key(8'h61 + 8'(i));
      rd(A_ERR);              check("ovf_err", rdata, 32'h4);
      wr(RGN_ERROR, 32'h4);
      rd(A_ERR);              check("w1c_err", rdata, 32'h0);
      // full FIFO: pop and push together
      addr = A_KBD; re = 1'b1; kbd_ascii = 8'h7A; kbd_valid = 1'b1;
      @(negedge clock);
      re = 1'b0; kbd_valid = 1'b0;
      check("full_pp", rdata, 32'h0000_1061);
      rd(A_ERR);              check("full_pp_err", rdata, 32'h0);
      for (int i = 0; i < 16; i++) rd(A_KBD);
      check("drain_last", rdata, 32'h0000_017A);
      // empty FIFO: pop sees empty, push lands
      addr = A_KBD; re = 1'b1; kbd_ascii = 8'h31; kbd_valid = 1'b1;
      @(negedge clock);
      re = 1'b0; kbd_valid = 1'b0;
      check("empty_pp", rdata, 32'h0);
      rd(A_KBD);              check("empty_pp_push", rdata, 32'h0000_0131);
      key(8'h00);
      rd(A_KBD);              check("nul_key", rdata, 32'h0);

      wr(RGN_SW, 32'h1);
      rd(A_ERR);              check("wr_sw_err", rdata, 32'h2);
      rd(32'hFFF0_0000);      check("rd_inv", rdata, 32'h0);
      rd(A_ERR);              check("rd_inv_err", rdata, 32'h3);
      for (int i = 0; i < 16; i++) key(8'h41 + 8'(i));
      addr = A_ERR; wdata = 32'h7; we = 1'b1; kbd_ascii = 8'h5A; kbd_valid = 1'b1;
      @(negedge clock);
      we = 1'b0; kbd_valid = 1'b0;
      rd(A_ERR);              check("set_beats_clr", rdata, 32'h4);
      addr = {RGN_LED, 20'h0}; wdata = 32'h5A5A; we = 1'b1; re = 1'b1;
      @(negedge clock);
      we = 1'b0; re = 1'b0;
      check("wr_rd_hold", rdata, 32'h4);
      check("wr_rd_led", 32'(led), 32'h5A5A);

      wr(RGN_HEX, 32'hDEAD_BEEF);
      wr(RGN_VGA_LINE, 32'hFFFF_FFF3);
      rd({RGN_VGA_LINE, 20'h0}); check("vga_rd", rdata, 32'h13);
      wr(RGN_DATA, 32'h1111_2222);
      mem_rdata = 32'h1234_5678;
      rd({RGN_DATA, 20'h10}); check("data_rd", rdata, 32'h1234_5678);
      mem_rdata = 32'hCAFE_F00D;
      @(negedge clock);
      rd({RGN_HEX, 20'h0});   check("hex_rd", rdata, 32'hDEAD_BEEF);

      wr(RGN_CLK_US, 32'hFFFF_FFFF);
      rd({RGN_CLK_US, 20'h0}); check("us_preset", rdata, 32'hFFFF_FFFF);
      rd({RGN_CLK_US, 20'h0}); check("us_wrap", rdata, 32'h0);
      wr(RGN_CLK_S, 32'h1234);
      rd({RGN_CLK_S, 20'h0}); check("s_preset", rdata, 32'h1234);
      wr(RGN_CLK_MS, 32'hFFFF_FFFF);
      repeat (1000) @(negedge clock);
      rd({RGN_CLK_MS, 20'h0}); check("ms_wrap", rdata, 32'h0);

      // reset mid-operation with strobes active
      reset = 1'b1; addr = {RGN_LED, 20'h0}; wdata = 32'hFFFF; we = 1'b1;
      re = 1'b1; kbd_ascii = 8'h44; kbd_valid = 1'b1;
      @(negedge clock);
      reset = 1'b0; we = 1'b0; re = 1'b0; kbd_valid = 1'b0;
      check("mid_rst_led", 32'(led), 32'h0);
      repeat (BLINK_MS * 1000 - 1) @(negedge clock);
      check("blink_before", 32'(cursor_blink), 32'h0);
      @(negedge clock);
      check("blink_toggle", 32'(cursor_blink), 32'h1);
      repeat (BLINK_MS * 1000) @(negedge clock);
      check("blink_back", 32'(cursor_blink), 32'h0);
      rd(A_KBD);              check("mid_rst_kbd", rdata, 32'h0);
      rd(A_ERR);              check("mid_rst_err", rdata, 32'h0);

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
